// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one single-port synchronous boot ROM between the CPU and the DMA
//   engine. Grants at most one read per clock (CPU has fixed priority), drives
//   the registered ROM address and tracks reads through a ROM_LAT-deep
//   owner pipeline. It returns the data and a one-cycle ack to the port that
//   issued the read.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cpu_req / cpu_addr   CPU level request and address (address stable while req is high)
//   cpu_dout / cpu_ack   CPU read data (held between acks) and one-cycle ack
//   dma_req / dma_addr   DMA level request and address
//   dma_dout / dma_ack   DMA read data (held between acks) and one-cycle ack
//   rom_a / rom_dout     registered ROM address, ROM read data
module rom_port_arbiter #(
  parameter int          ADDR_W  = 15,
  parameter int          DATA_W  = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_dout,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_dout
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  logic [ROM_LAT:0] s_vld;
  owner_t           s_own [ROM_LAT+1];
  logic             cpu_busy, dma_busy;

  logic cpu_elig, dma_elig;
  logic grant_cpu, grant_dma;
  logic done_cpu, done_dma;

  // A port waits one full cycle after its ack before it can be granted again.
  // This gives the requester the ack cycle to change or drop its request.
  assign cpu_elig  = cpu_req & ~cpu_busy & ~cpu_ack;
  assign dma_elig  = dma_req & ~dma_busy & ~dma_ack;
  assign grant_cpu = cpu_elig;
  assign grant_dma = dma_elig & ~cpu_elig;

  // The tail stage holds the read whose data is on rom_dout during this cycle.
  assign done_cpu = s_vld[ROM_LAT] & (s_own[ROM_LAT] == OWN_CPU);
  assign done_dma = s_vld[ROM_LAT] & (s_own[ROM_LAT] == OWN_DMA);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_a    <= '0;
      cpu_dout <= '0;
      dma_dout <= '0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      cpu_busy <= 1'b0;
      dma_busy <= 1'b0;
      s_vld    <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) s_own[k] <= OWN_CPU;
    end else begin
      cpu_ack <= done_cpu;
      dma_ack <= done_dma;
      if (done_cpu) cpu_dout <= rom_dout;
      if (done_dma) dma_dout <= rom_dout;

      // A grant needs ~busy and completion needs busy, so the two never
      // coincide for the same port.
      if (grant_cpu)     cpu_busy <= 1'b1;
      else if (done_cpu) cpu_busy <= 1'b0;
      if (grant_dma)     dma_busy <= 1'b1;
      else if (done_dma) dma_busy <= 1'b0;

      if (grant_cpu)      rom_a <= cpu_addr;
      else if (grant_dma) rom_a <= dma_addr;

      s_vld[0] <= grant_cpu | grant_dma;
      s_own[0] <= grant_cpu ? OWN_CPU : OWN_DMA;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        s_vld[k] <= s_vld[k-1];
        s_own[k] <= s_own[k-1];
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//   Drives directed and randomized CPU/DMA traffic into rom_port_arbiter in
//   front of a behavioural 32K x 8 ROM. Every output is compared each cycle
//   against a timestamp-based reference model of the arbitration rules.
module tb_rom_port_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, dma_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_dout, dma_dout, rom_dout;
  logic          cpu_ack, dma_ack;
  logic [AW-1:0] rom_a;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_dout <= mem[rom_a];

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_ack(dma_ack),
    .rom_a(rom_a), .rom_dout(rom_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = CPU, 1 = DMA. Each outstanding read records
  // the edge number at which it is due and the data it must return.
  int            cyc = 0;
  bit            m_busy [2];
  int            m_due  [2];
  logic [DW-1:0] m_data [2];
  bit            m_ack  [2];
  logic [DW-1:0] m_dout [2];
  logic [AW-1:0] m_rom_a;
  int            m_grants [2];

  task automatic model_edge(input bit r, input bit [1:0] req, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
    bit elig [2];
    int win;
    cyc++;
    if (r) begin
      for (int p = 0; p < 2; p++) begin
        m_busy[p] = 0; m_ack[p] = 0; m_dout[p] = '0;
      end
      m_rom_a = '0;
      return;
    end
    for (int p = 0; p < 2; p++) elig[p] = req[p] && !m_busy[p] && !m_ack[p];
    for (int p = 0; p < 2; p++) begin
      m_ack[p] = m_busy[p] && (m_due[p] == cyc);
      if (m_ack[p]) begin
        m_dout[p] = m_data[p];
        m_busy[p] = 0;
      end
    end
    win = elig[0] ? 0 : (elig[1] ? 1 : -1);
    if (win >= 0) begin
      m_rom_a       = (win == 0) ? a0 : a1;
      m_busy[win]   = 1;
      m_due[win]    = cyc + LAT + 1;
      m_data[win]   = mem[m_rom_a];
      m_grants[win]++;
    end
  endtask

  // Drive inputs (called at a negedge), apply the model edge, then compare
  // every output on the following negedge.
  task automatic cycle(input bit r, input bit cr, input logic [AW-1:0] ca,
                       input bit dr, input logic [AW-1:0] da);
    rst = r; cpu_req = cr; cpu_addr = ca; dma_req = dr; dma_addr = da;
    model_edge(r, {dr, cr}, ca, da);
    @(posedge clk);
    @(negedge clk);
    check("rom_a",    32'(rom_a),    32'(m_rom_a));
    check("cpu_ack",  32'(cpu_ack),  32'(m_ack[0]));
    check("dma_ack",  32'(dma_ack),  32'(m_ack[1]));
    check("cpu_dout", 32'(cpu_dout), 32'(m_dout[0]));
    check("dma_dout", 32'(dma_dout), 32'(m_dout[1]));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    int cpu_acks, dma_acks;
    logic [AW-1:0] ca, da;
    bit cr, dr;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[15'h0000] = 8'hF3;
    mem[15'h0010] = 8'h5A;
    mem[15'h7FFF] = 8'hC7;

    // 1: single CPU read of address 0, ack after the third edge
    cycle(1, 0, '0, 0, '0);
    cycle(1, 0, '0, 0, '0);
    check("t1_rst_ack", 32'(cpu_ack), 32'd0);
    cycle(0, 1, 15'h0000, 0, '0);
    check("t1_rom_a", 32'(rom_a), 32'h0000);
    cycle(0, 1, 15'h0000, 0, '0);
    check("t1_no_early_ack", 32'(cpu_ack), 32'd0);
    cycle(0, 1, 15'h0000, 0, '0);
    check("t1_ack", 32'(cpu_ack), 32'd1);
    check("t1_dout", 32'(cpu_dout), 32'hF3);
    check("t1_dma_quiet", 32'(dma_ack), 32'd0);
    cycle(0, 0, '0, 0, '0);
    repeat (3) cycle(0, 0, '0, 0, '0);

    // 2: simultaneous requests, CPU first, DMA one edge later at 0x7FFF
    cycle(0, 1, 15'h0010, 1, 15'h7FFF);
    check("t2_rom_a_cpu", 32'(rom_a), 32'h0010);
    cycle(0, 1, 15'h0010, 1, 15'h7FFF);
    check("t2_rom_a_dma", 32'(rom_a), 32'h7FFF);
    cycle(0, 1, 15'h0010, 1, 15'h7FFF);
    check("t2_cpu_dout", 32'(cpu_dout), 32'h5A);
    cycle(0, 0, '0, 1, 15'h7FFF);
    check("t2_dma_ack", 32'(dma_ack), 32'd1);
    check("t2_dma_dout", 32'(dma_dout), 32'hC7);
    cycle(0, 0, '0, 0, '0);
    repeat (3) cycle(0, 0, '0, 0, '0);

    // 3: CPU chains 0x100..0x103 while DMA holds its request until one ack
    cpu_acks = 0; dma_acks = 0;
    ca = 15'h0100; cr = 1; dr = 1; da = 15'h2222;
    for (int i = 0; i < 40 && (cr || dr); i++) begin
      cycle(0, cr, ca, dr, da);
      if (cpu_ack) begin
        cpu_acks++;
        if (cpu_acks == 4) cr = 0; else ca = ca + 1'b1;
      end
      if (dma_ack) begin
        dma_acks++;
        dr = 0;
      end
    end
    check("t3_cpu_acks", 32'(cpu_acks), 32'd4);
    check("t3_dma_acks", 32'(dma_acks), 32'd1);
    repeat (4) cycle(0, 0, '0, 0, '0);

    // 4: request held through the ack re-issues the same read exactly once
    m_grants[0] = 0;
    repeat (6) cycle(0, 1, 15'h0333, 0, '0);
    check("t4_grants", 32'(m_grants[0]), 32'd2);
    repeat (4) cycle(0, 0, '0, 0, '0);

    // 5: reset one cycle after a CPU grant drops the read
    cycle(0, 1, 15'h0444, 0, '0);
    cycle(1, 1, 15'h0444, 0, '0);
    check("t5_rst_rom_a", 32'(rom_a), 32'd0);
    check("t5_rst_ack", 32'(cpu_ack), 32'd0);
    cycle(0, 0, '0, 0, '0);
    check("t5_no_late_ack", 32'(cpu_ack), 32'd0);
    cycle(0, 1, 15'h0010, 0, '0);
    cycle(0, 1, 15'h0010, 0, '0);
    cycle(0, 1, 15'h0010, 0, '0);
    check("t5_fresh_ack", 32'(cpu_ack), 32'd1);
    check("t5_fresh_dout", 32'(cpu_dout), 32'h5A);
    repeat (4) cycle(0, 0, '0, 0, '0);

    // 6: DMA aborts one cycle after its grant; ack still pulses once
    m_grants[1] = 0;
    cycle(0, 0, '0, 1, 15'h7FFF);
    cycle(0, 0, '0, 0, '0);
    cycle(0, 0, '0, 0, '0);
    check("t6_abort_ack", 32'(dma_ack), 32'd1);
    check("t6_abort_dout", 32'(dma_dout), 32'hC7);
    repeat (3) cycle(0, 0, '0, 0, '0);
    check("t6_grants", 32'(m_grants[1]), 32'd1);

    // Random traffic with occasional aborts, address changes and resets
    cr = 0; dr = 0; ca = '0; da = '0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 99) < 2);
      if (!cr) begin
        if ($urandom_range(0, 99) < 40) begin cr = 1; ca = rand_addr(); end
      end else if (m_ack[0]) begin
        case ($urandom_range(0, 2))
          0: cr = 0;
          1: ca = rand_addr();
          default: ;
        endcase
      end else if ($urandom_range(0, 99) < 5) cr = 0;
      if (!dr) begin
        if ($urandom_range(0, 99) < 40) begin dr = 1; da = rand_addr(); end
      end else if (m_ack[1]) begin
        case ($urandom_range(0, 2))
          0: dr = 0;
          1: da = rand_addr();
          default: ;
        endcase
      end else if ($urandom_range(0, 99) < 5) dr = 0;
      cycle(r, cr, ca, dr, da);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
